// File: rtl/one_in_conditioner.sv
// rtl/one_in_conditioner.sv - raw input synchroniser, debouncer and edge-strobe generator
//
// Purpose: brings an asynchronous raw line into clk, debounces it with a
// four-state FSM and drives a clean registered level plus edge strobes.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   raw_in     raw asynchronous input line
//   one_in     debounced level (registered)
//   rise_pulse one-clk strobe on the edge one_in goes 0->1
//   fall_pulse one-clk strobe on the edge one_in goes 1->0
//   busy       high while a transition is being qualified
//   glitch_cnt saturating count of aborted transitions
module one_in_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_in,
    output logic       one_in,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHK_HIGH    = 2'd1,
        STABLE_HIGH = 2'd2,
        CHK_LOW     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    // Bit 0 is the metastability-exposed stage; only the last stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STABLE_LOW;
            cnt        <= '0;
            one_in     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            glitch_cnt <= 8'd0;
        end else begin
            // Strobes default low so each lasts exactly one clock.
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        state <= CHK_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                CHK_HIGH: begin
                    if (!s) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                        if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
                    end else if (cnt == CNT_LAST) begin
                        state      <= STABLE_HIGH;
                        cnt        <= '0;
                        one_in     <= 1'b1;
                        rise_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state <= CHK_LOW;
                        cnt   <= CNT_ONE;
                    end
                end
                CHK_LOW: begin
                    if (s) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                        if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
                    end else if (cnt == CNT_LAST) begin
                        state      <= STABLE_LOW;
                        cnt        <= '0;
                        one_in     <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == CHK_HIGH) || (state == CHK_LOW);

endmodule

// File: tb/tb_one_in_conditioner.sv
// tb/tb_one_in_conditioner.sv - directed self-checking bench for one_in_conditioner
module tb_one_in_conditioner;

    logic       clk;
    logic       rst_n;
    logic       raw_in;
    logic       one_in;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       busy;
    logic [7:0] glitch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    one_in_conditioner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .one_in     (one_in),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_one_in"}, int'(one_in), 0);
        check({tag, "_rise"}, int'(rise_pulse), 0);
        check({tag, "_fall"}, int'(fall_pulse), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_glitch"}, int'(glitch_cnt), 0);
    endtask

    int rises, falls, busy_n, high_n, rise_edge, fall_edge;

    initial begin
        rst_n  = 1'b0;
        raw_in = 1'b1;

        // T1: reset with raw_in high, then 6-edge latency to one_in.
        step();
        step();
        check_all_zero("t1_reset");
        rst_n = 1'b1;
        rises = 0; rise_edge = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (rise_pulse) begin
                rises++;
                if (rise_edge == 0) rise_edge = i;
            end
            if (i == 5) check("t1_one_in_e5", int'(one_in), 0);
            if (i == 6) check("t1_one_in_e6", int'(one_in), 1);
            if (i == 7) check("t1_rise_e7", int'(rise_pulse), 0);
        end
        check("t1_rise_edge", rise_edge, 6);
        check("t1_rise_count", rises, 1);
        check("t1_glitch", int'(glitch_cnt), 0);

        // T3: settled high, raw low for 10 clocks.
        raw_in = 1'b0;
        falls = 0; rises = 0; fall_edge = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (fall_pulse) falls++;
            if (rise_pulse) rises++;
            if (!one_in && fall_edge == 0) fall_edge = i;
        end
        check("t3_fall_edge", fall_edge, 6);
        check("t3_fall_count", falls, 1);
        check("t3_rise_count", rises, 0);
        check("t3_glitch", int'(glitch_cnt), 0);

        // T2: three-clock high glitch.
        rises = 0; falls = 0; busy_n = 0; high_n = 0;
        for (int i = 1; i <= 12; i++) begin
            raw_in = (i <= 3);
            step();
            if (rise_pulse) rises++;
            if (fall_pulse) falls++;
            if (busy) busy_n++;
            if (one_in) high_n++;
        end
        check("t2_one_in_high", high_n, 0);
        check("t2_strobes", rises + falls, 0);
        check("t2_busy_clks", busy_n, 3);
        check("t2_glitch", int'(glitch_cnt), 1);

        // T4: bounce 1,0,1,0,1 then held high.
        rises = 0; rise_edge = 0;
        for (int i = 1; i <= 15; i++) begin
            raw_in = (i == 2 || i == 4) ? 1'b0 : 1'b1;
            step();
            if (rise_pulse) begin
                rises++;
                if (rise_edge == 0) rise_edge = i;
            end
        end
        check("t4_rise_count", rises, 1);
        check("t4_rise_edge", rise_edge, 10);
        check("t4_one_in", int'(one_in), 1);
        check("t4_glitch", int'(glitch_cnt), 3);

        // Return to a settled low level.
        raw_in = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("pre_t5_one_in", int'(one_in), 0);
        check("pre_t5_glitch", int'(glitch_cnt), 3);

        // T5: 300 three-clock glitches; count saturates at 255.
        high_n = 0; rises = 0;
        for (int r = 1; r <= 300; r++) begin
            for (int i = 0; i < 6; i++) begin
                raw_in = (i < 3);
                step();
                if (one_in) high_n++;
                if (rise_pulse) rises++;
            end
            if (r == 251) check("t5_glitch_254", int'(glitch_cnt), 254);
            if (r == 252) check("t5_glitch_255", int'(glitch_cnt), 255);
        end
        raw_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t5_glitch_hold", int'(glitch_cnt), 255);
        check("t5_one_in_high", high_n, 0);
        check("t5_rise_count", rises, 0);

        // T6: reset while in CHK_HIGH with cnt=2, no clock edge needed.
        raw_in = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t6_busy_pre", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        rst_n = 1'b1;
        rise_edge = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (rise_pulse && rise_edge == 0) rise_edge = i;
        end
        check("t6_rise_edge", rise_edge, 6);
        check("t6_one_in", int'(one_in), 1);
        check("t6_glitch", int'(glitch_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Strobes must never assert together.
    always @(negedge clk) begin
        if (rise_pulse && fall_pulse) begin
            check("both_strobes", 1, 0);
        end
    end

endmodule
